// File: rtl/msu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : msu_pkg
// Description : Shared types and constants for the MSU data prefetcher.
//               Holds the prefetch FSM state encoding, the smallest legal
//               buffer depth and a depth-legality helper.
// Revision    : 1.0 - initial release
// ============================================================================
package msu_pkg;

    // Prefetch controller states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,   // no outstanding host request
        ST_REQ  = 2'd1,   // host_rd_req asserted, waiting for host_rd_ack
        ST_HOLD = 2'd2    // fewer than two free bytes in the buffer
    } msu_state_e;

    // A host word is two bytes, so the buffer must hold at least two words.
    localparam int unsigned c_min_depth = 4;

    // Depth must be a power of two (pointer wrap relies on it) and >= minimum.
    function automatic bit msu_depth_ok(input int unsigned depth);
        return (depth >= c_min_depth) && ((depth & (depth - 1)) == 0);
    endfunction

endpackage : msu_pkg
`default_nettype wire

// File: rtl/msu_prefetch_fifo.sv
`default_nettype none
// ============================================================================
// Module      : msu_prefetch_fifo
// Description : Circular byte buffer for the MSU data prefetcher.
//               Accepts 0, 1 or 2 bytes per cycle (low byte first), pops at
//               most one byte per cycle and can be flushed in one cycle.
// Ports       : CLK, RST_N     - clock, asynchronous active-low reset
//               i_flush        - empty the buffer (wins over push and pop)
//               i_push_n       - number of bytes to push (0..2)
//               i_push_data    - [7:0] pushed first, [15:8] second
//               i_pop          - drop the head byte (ignored when empty)
//               o_head         - byte at the read pointer
//               o_count        - bytes currently stored (0..DEPTH)
// Revision    : 1.0 - initial release
// ============================================================================
module msu_prefetch_fifo #(
    parameter int unsigned DEPTH = 8
) (
    input  logic                     CLK,
    input  logic                     RST_N,
    input  logic                     i_flush,
    input  logic [1:0]               i_push_n,
    input  logic [15:0]              i_push_data,
    input  logic                     i_pop,
    output logic [7:0]               o_head,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int unsigned c_aw = $clog2(DEPTH);

    logic [7:0]      r_mem [DEPTH];
    logic [c_aw-1:0] r_wr_ptr;
    logic [c_aw-1:0] r_rd_ptr;
    logic [c_aw:0]   r_count;

    logic [1:0]      w_push_n;
    logic            w_pop_ok;

    // An encoding of 3 is not meaningful; treat it as a two-byte push.
    assign w_push_n = (i_push_n == 2'd3) ? 2'd2 : i_push_n;
    assign w_pop_ok = i_pop && (r_count != '0);

    // Storage carries no reset; validity is tracked by r_count alone.
    always_ff @(posedge CLK) begin
        if (!i_flush) begin
            if (w_push_n != 2'd0) begin
                r_mem[r_wr_ptr] <= i_push_data[7:0];
            end
            if (w_push_n == 2'd2) begin
                r_mem[r_wr_ptr + c_aw'(1)] <= i_push_data[15:8];
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            r_wr_ptr <= r_wr_ptr + c_aw'(w_push_n);
            r_rd_ptr <= r_rd_ptr + c_aw'(w_pop_ok);
            r_count  <= r_count + (c_aw + 1)'(w_push_n) - (c_aw + 1)'(w_pop_ok);
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule : msu_prefetch_fifo
`default_nettype wire

// File: rtl/msu_data_prefetch.sv
`default_nettype none
// ============================================================================
// Module      : msu_data_prefetch
// Description : Byte-stream prefetcher for the MSU data file. Fetches 16-bit
//               words from the host memory port into a small byte buffer and
//               presents one byte at a time to the consumer.
// Ports       : CLK, RST_N     - clock, asynchronous active-low reset
//               seek/seek_addr - jump to a new byte position
//               req            - consumer took data_out, advance one byte
//               data_out, busy - current byte, high while it is not valid
//               host_rd_req/host_rd_addr - level read request to the host
//               host_rd_ack/host_rd_data - completion pulse and word
// Revision    : 1.0 - initial release
// ============================================================================
module msu_data_prefetch
    import msu_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        seek,
    input  logic [31:0] seek_addr,
    input  logic        req,
    output logic [7:0]  data_out,
    output logic        busy,
    output logic        host_rd_req,
    output logic [31:0] host_rd_addr,
    input  logic        host_rd_ack,
    input  logic [15:0] host_rd_data
);

    localparam int unsigned c_cw = $clog2(DEPTH) + 1;

    generate
        if (!msu_depth_ok(DEPTH)) begin : g_depth_invalid
            $error("msu_data_prefetch: DEPTH must be a power of two and at least 4");
        end
    endgenerate

    msu_state_e  r_state;
    logic [31:0] r_fetch_ptr;    // address of the outstanding / next fetch
    logic        r_skip;         // drop the low byte of the next kept word
    logic        r_seek_seen;
    logic        r_discard;      // outstanding word belongs to a stale seek
    logic        r_host_rd_req;
    logic [31:0] r_host_rd_addr;

    logic [c_cw-1:0] w_count;
    logic [7:0]      w_head;
    logic            w_free_ok;
    logic            w_take;
    logic [1:0]      w_push_n;
    logic [15:0]     w_push_data;
    logic            w_pop;
    logic [31:0]     w_seek_word;

    assign w_seek_word = {seek_addr[31:1], 1'b0};
    assign w_free_ok   = (w_count <= c_cw'(DEPTH - 2));

    // A seek in the ack cycle makes the returned word stale, so it is dropped.
    assign w_take      = (r_state == ST_REQ) && host_rd_ack && !r_discard && !seek;
    assign w_push_n    = w_take ? (r_skip ? 2'd1 : 2'd2) : 2'd0;
    assign w_push_data = r_skip ? {8'h00, host_rd_data[15:8]} : host_rd_data;
    assign w_pop       = req && !seek;

    msu_prefetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .CLK         (CLK),
        .RST_N       (RST_N),
        .i_flush     (seek),
        .i_push_n    (w_push_n),
        .i_push_data (w_push_data),
        .i_pop       (w_pop),
        .o_head      (w_head),
        .o_count     (w_count)
    );

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state        <= ST_IDLE;
            r_fetch_ptr    <= '0;
            r_skip         <= 1'b0;
            r_seek_seen    <= 1'b0;
            r_discard      <= 1'b0;
            r_host_rd_req  <= 1'b0;
            r_host_rd_addr <= '0;
        end else if (seek) begin
            r_seek_seen <= 1'b1;
            r_skip      <= seek_addr[0];
            r_fetch_ptr <= w_seek_word;
            if ((r_state == ST_REQ) && !host_rd_ack) begin
                // Host still owes a word: keep the request up, drop its data.
                r_discard <= 1'b1;
            end else begin
                // Buffer is flushed this edge, so space is guaranteed.
                r_discard      <= 1'b0;
                r_host_rd_req  <= 1'b1;
                r_host_rd_addr <= w_seek_word;
                r_state        <= ST_REQ;
            end
        end else begin
            case (r_state)
                ST_REQ: begin
                    if (host_rd_ack) begin
                        r_host_rd_req <= 1'b0;
                        r_state       <= ST_IDLE;
                        if (r_discard) begin
                            r_discard <= 1'b0;
                        end else begin
                            r_fetch_ptr <= r_fetch_ptr + 32'd2;
                            r_skip      <= 1'b0;
                        end
                    end
                end
                default: begin
                    // IDLE and HOLD: issue once two bytes are free.
                    if (r_seek_seen) begin
                        if (w_free_ok) begin
                            r_host_rd_req  <= 1'b1;
                            r_host_rd_addr <= r_fetch_ptr;
                            r_state        <= ST_REQ;
                        end else begin
                            r_state <= ST_HOLD;
                        end
                    end
                end
            endcase
        end
    end

    assign host_rd_req  = r_host_rd_req;
    assign host_rd_addr = r_host_rd_addr;
    assign data_out     = (w_count != '0) ? w_head : 8'h00;
    assign busy         = r_seek_seen && (w_count == '0);

endmodule : msu_data_prefetch
`default_nettype wire

// File: tb/tb_msu_data_prefetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_msu_data_prefetch
// Description : Directed self-checking bench for msu_data_prefetch (DEPTH=8).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_msu_data_prefetch;
    import msu_pkg::*;

    logic        CLK;
    logic        RST_N;
    logic        seek;
    logic [31:0] seek_addr;
    logic        req;
    logic [7:0]  data_out;
    logic        busy;
    logic        host_rd_req;
    logic [31:0] host_rd_addr;
    logic        host_rd_ack;
    logic [15:0] host_rd_data;

    int n_checks = 0;
    int n_fail   = 0;

    msu_data_prefetch #(.DEPTH(8)) dut (
        .CLK          (CLK),
        .RST_N        (RST_N),
        .seek         (seek),
        .seek_addr    (seek_addr),
        .req          (req),
        .data_out     (data_out),
        .busy         (busy),
        .host_rd_req  (host_rd_req),
        .host_rd_addr (host_rd_addr),
        .host_rd_ack  (host_rd_ack),
        .host_rd_data (host_rd_data)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 ns after it.
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_seek(input logic [31:0] a);
        seek = 1'b1; seek_addr = a;
        step();
        seek = 1'b0;
    endtask

    task automatic do_ack(input logic [15:0] d);
        host_rd_ack = 1'b1; host_rd_data = d;
        step();
        host_rd_ack = 1'b0;
    endtask

    task automatic do_req();
        req = 1'b1;
        step();
        req = 1'b0;
    endtask

    task automatic wait_req(input string tag, input int max_cycles);
        for (int i = 0; i < max_cycles && !host_rd_req; i++) step();
        check_eq(tag, host_rd_req, 1);
    endtask

    logic [31:0] exp_addr [4];

    initial begin
        exp_addr[0] = 32'hFFFF_FFFE;
        exp_addr[1] = 32'h0000_0000;
        exp_addr[2] = 32'h0000_0002;
        exp_addr[3] = 32'h0000_0004;

        RST_N = 1'b0; seek = 1'b0; seek_addr = '0; req = 1'b0;
        host_rd_ack = 1'b0; host_rd_data = '0;
        step(); step();

        // Reset state
        check_eq("rst_req",   host_rd_req,  0);
        check_eq("rst_addr",  host_rd_addr, 0);
        check_eq("rst_busy",  busy,         0);
        check_eq("rst_data",  data_out,     0);
        check_eq("rst_count", dut.w_count,  0);
        RST_N = 1'b1;
        step();

        // No fetch before the first seek; stray ack ignored
        do_ack(16'h5A5A);
        step(); step();
        check_eq("preseek_req",   host_rd_req, 0);
        check_eq("preseek_count", dut.w_count, 0);
        check_eq("preseek_busy",  busy,        0);

        // Aligned seek
        do_seek(32'h0000_0100);
        check_eq("s100_req",  host_rd_req,  1);
        check_eq("s100_addr", host_rd_addr, 32'h100);
        check_eq("s100_busy", busy,         1);
        do_ack(16'hBBAA);
        check_eq("s100_data0", data_out,    8'hAA);
        check_eq("s100_busy0", busy,        0);
        check_eq("s100_cnt0",  dut.w_count, 2);
        do_req();
        check_eq("s100_data1", data_out,     8'hBB);
        check_eq("s100_cnt1",  dut.w_count,  1);
        check_eq("s100_addr2", host_rd_addr, 32'h102);
        check_eq("s100_req2",  host_rd_req,  1);
        do_ack(16'hDDCC);
        check_eq("s100_cnt2",  dut.w_count, 3);
        check_eq("s100_data2", data_out,    8'hBB);

        // Odd seek: low byte of the first word skipped
        do_seek(32'h0000_0101);
        check_eq("s101_addr", host_rd_addr, 32'h100);
        check_eq("s101_cnt0", dut.w_count,  0);
        do_ack(16'hBBAA);
        check_eq("s101_cnt1", dut.w_count, 1);
        check_eq("s101_data", data_out,    8'hBB);
        check_eq("s101_busy", busy,        0);
        do_req();
        check_eq("s101_busy_pop", busy,     1);
        check_eq("s101_data_pop", data_out, 0);
        do_req();
        check_eq("s101_empty_pop", dut.w_count, 0);

        // Seek together with ack of the outstanding request
        seek = 1'b1; seek_addr = 32'h200; host_rd_ack = 1'b1; host_rd_data = 16'h9999;
        step();
        seek = 1'b0; host_rd_ack = 1'b0;
        check_eq("s200_req",  host_rd_req,  1);
        check_eq("s200_addr", host_rd_addr, 32'h200);
        check_eq("s200_cnt",  dut.w_count,  0);

        // Seek while unacked: stale word discarded
        do_seek(32'h400);
        check_eq("s400_hold_addr", host_rd_addr, 32'h200);
        check_eq("s400_hold_req",  host_rd_req,  1);
        do_ack(16'h1111);
        check_eq("s400_discard", dut.w_count, 0);
        check_eq("s400_busy",    busy,        1);
        wait_req("s400_wait", 4);
        check_eq("s400_addr", host_rd_addr, 32'h400);
        do_ack(16'h2222);
        check_eq("s400_data", data_out,    8'h22);
        check_eq("s400_cnt",  dut.w_count, 2);

        // Address wrap and HOLD with DEPTH=8
        do_seek(32'hFFFF_FFFE);
        for (int i = 0; i < 4; i++) begin
            wait_req("wrap_wait", 4);
            check_eq("wrap_addr", host_rd_addr, exp_addr[i]);
            do_ack({4'hA, 4'(2*i+1), 4'hA, 4'(2*i)});
        end
        step(); step();
        check_eq("hold_state", dut.r_state, ST_HOLD);
        check_eq("hold_req",   host_rd_req, 0);
        check_eq("hold_cnt",   dut.w_count, 8);
        check_eq("hold_data",  data_out,    8'hA0);
        do_req();
        check_eq("hold_cnt7",  dut.w_count, 7);
        check_eq("hold_data7", data_out,    8'hA1);
        step(); step();
        check_eq("hold_req7",  host_rd_req, 0);
        do_req();
        check_eq("hold_cnt6",  dut.w_count, 6);
        wait_req("hold_wait", 4);
        check_eq("hold_addr6", host_rd_addr, 32'h6);

        // Asynchronous reset during an outstanding request
        #2;
        RST_N = 1'b0;
        #1;
        check_eq("arst_req",  host_rd_req, 0);
        check_eq("arst_busy", busy,        0);
        step();
        RST_N = 1'b1;
        do_ack(16'h7777);
        check_eq("arst_cnt",  dut.w_count, 0);
        check_eq("arst_busy2", busy,       0);
        step(); step(); step();
        check_eq("arst_noreq", host_rd_req, 0);
        do_seek(32'h300);
        check_eq("arst_seek_addr", host_rd_addr, 32'h300);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_msu_data_prefetch
`default_nettype wire
